// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode field location and boot defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    VEC  = 2'd1,
    OPC  = 2'd2,
    IMM  = 2'd3
  } fetch_state_e;

  localparam int OPC_FIELD_MSB = 7;
  localparam int OPC_FIELD_LSB = 4;

  localparam logic [7:0]  CPU_RESET_VECTOR_ADDR = 8'h00;
  localparam logic [15:0] CPU_TWO_BYTE_MASK     = 16'h1000;

  // Opcode class field of an instruction byte; selects a bit of the two-byte mask.
  function automatic logic [3:0] opcode_field(input logic [7:0] b);
    return b[OPC_FIELD_MSB:OPC_FIELD_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: boots from a memory-held reset vector, assembles
// 1/2-byte instructions from a 1-cycle-latency memory and hands them to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0]  RESET_VECTOR_ADDR = CPU_RESET_VECTOR_ADDR,
  parameter logic [15:0] TWO_BYTE_MASK     = CPU_TWO_BYTE_MASK
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pc_addr,
  input  logic [7:0] instr_in,
  input  logic       stall,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic       fetch_valid,
  output logic [7:0] ir_out,
  output logic [7:0] imm_out,
  output logic [7:0] out_pc,
  output logic [7:0] out_pc_next
);

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   f_pc_q, f_pc_d;
  logic         f_vld_q, f_vld_d;
  logic         fetch_valid_q, fetch_valid_d;
  logic [7:0]   ir_q, ir_d;
  logic [7:0]   imm_q, imm_d;
  logic [7:0]   out_pc_q, out_pc_d;
  logic [7:0]   out_pc_next_q, out_pc_next_d;
  logic [7:0]   pc_addr_s;
  logic         hold_s;

  // Next-state, address generation and instruction capture.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f_pc_d        = f_pc_q;
    f_vld_d       = f_vld_q;
    fetch_valid_d = fetch_valid_q;
    ir_d          = ir_q;
    imm_d         = imm_q;
    out_pc_d      = out_pc_q;
    out_pc_next_d = out_pc_next_q;
    pc_addr_s     = pc_q;
    hold_s        = fetch_valid_q & stall & ~redirect_valid;

    case (state_q)
      BOOT: begin
        pc_addr_s = RESET_VECTOR_ADDR;
        state_d   = VEC;
      end
      VEC: begin
        pc_d    = instr_in;
        f_vld_d = 1'b0;
        state_d = OPC;
      end
      OPC, IMM: begin
        if (redirect_valid) begin
          pc_d          = redirect_pc;
          f_vld_d       = 1'b0;
          fetch_valid_d = 1'b0;
          state_d       = OPC;
        end else if (hold_s) begin
          // Re-read the address whose data is being discarded this cycle.
          pc_addr_s = f_pc_q;
        end else begin
          f_pc_d        = pc_q;
          f_vld_d       = 1'b1;
          pc_d          = pc_q + 8'd1;
          fetch_valid_d = 1'b0;
          if (f_vld_q) begin
            if (state_q == OPC) begin
              ir_d     = instr_in;
              out_pc_d = f_pc_q;
              if (TWO_BYTE_MASK[opcode_field(instr_in)]) begin
                state_d = IMM;
              end else begin
                imm_d         = 8'h00;
                out_pc_next_d = f_pc_q + 8'd1;
                fetch_valid_d = 1'b1;
              end
            end else begin
              imm_d         = instr_in;
              out_pc_next_d = out_pc_q + 8'd2;
              fetch_valid_d = 1'b1;
              state_d       = OPC;
            end
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR_ADDR;
      f_pc_q        <= 8'h00;
      f_vld_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      ir_q          <= 8'h00;
      imm_q         <= 8'h00;
      out_pc_q      <= 8'h00;
      out_pc_next_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f_pc_q        <= f_pc_d;
      f_vld_q       <= f_vld_d;
      fetch_valid_q <= fetch_valid_d;
      ir_q          <= ir_d;
      imm_q         <= imm_d;
      out_pc_q      <= out_pc_d;
      out_pc_next_q <= out_pc_next_d;
    end
  end

  assign pc_addr     = pc_addr_s;
  assign fetch_valid = fetch_valid_q;
  assign ir_out      = ir_q;
  assign imm_out     = imm_q;
  assign out_pc      = out_pc_q;
  assign out_pc_next = out_pc_next_q;

endmodule
